// File: rtl/frame_issue_ctrl.sv
// Frame issue controller: load-use stall, flush bubbles and frame write enables.
// Define STALL_COUNT_EN to add the stall_count output and its counter.
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

module frame_issue_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    output logic                      dec_ready,
    input  logic [`REGADDR_WIDTH-1:0] dec_aLoc,
    input  logic [`REGADDR_WIDTH-1:0] dec_bLoc,
    input  logic [`REGADDR_WIDTH-1:0] dec_writeSelect,
    input  logic                      dec_load,
    input  logic                      exe_ready,
    input  logic                      flush,
    output logic                      operand_we,
    output logic                      control_we,
    output logic                      bubble
`ifdef STALL_COUNT_EN
    ,
    output logic [STALL_CNT_W-1:0]    stall_count
`endif
);

    localparam int RW    = `REGADDR_WIDTH;
    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    if (STALL_CNT_W < 1) begin : g_bad_cfg
        $error("STALL_CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {RUN, LDUSE, FLUSH} state_t;

    state_t           state_q, state_d;
    logic             last_load_q, last_load_d;
    logic [RW-1:0]    last_rd_q, last_rd_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             hazard;
    logic             transfer;

    always_comb begin
        hazard = dec_valid & last_load_q & (last_rd_q != '0) &
                 ((dec_aLoc == last_rd_q) | (dec_bLoc == last_rd_q));
        // LDUSE accepts: the hazard cycle already spent the single bubble.
        dec_ready = reset & exe_ready & (state_q != FLUSH) & ~hazard & ~flush;
        transfer  = dec_valid & dec_ready;

        if (!reset) begin
            operand_we = 1'b0;
            control_we = 1'b1;
            bubble     = 1'b1;
        end else if (!exe_ready) begin
            operand_we = 1'b0;
            control_we = 1'b0;
            bubble     = 1'b0;
        end else begin
            operand_we = transfer;
            control_we = 1'b1;
            bubble     = ~transfer;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_load_d = last_load_q;
        last_rd_d   = last_rd_q;
        fcnt_d      = fcnt_q;

        // Flush is latched even while the frame is stalled.
        if (flush) begin
            state_d     = FLUSH;
            fcnt_d      = CNT_W'(FLUSH_CYCLES);
            last_load_d = 1'b0;
        end else if (exe_ready) begin
            if (transfer) begin
                last_load_d = dec_load;
                last_rd_d   = dec_writeSelect;
            end else begin
                last_load_d = 1'b0;
            end
            case (state_q)
                RUN:   if (hazard) state_d = LDUSE;
                LDUSE: state_d = RUN;
                FLUSH: begin
                    if (fcnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - CNT_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            last_load_q <= 1'b0;
            last_rd_q   <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_load_q <= last_load_d;
            last_rd_q   <= last_rd_d;
            fcnt_q      <= fcnt_d;
        end
    end

`ifdef STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   stall_inc;

    // Plain decoder starvation in RUN is not a stall.
    always_comb begin
        stall_inc = reset & exe_ready & ~transfer & ((state_q != RUN) | hazard);
        stall_d   = stall_q + STALL_CNT_W'(stall_inc);
    end

    always_ff @(posedge clk) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_frame_issue_ctrl.sv
// Bench for frame_issue_ctrl: directed vector table, flush-restart sequence,
// then random stimulus against a behavioural model.
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

module tb_frame_issue_ctrl;
    localparam int FC = 2;
    localparam int RW = `REGADDR_WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dec_valid = 1'b0;
    logic          dec_ready;
    logic [RW-1:0] dec_aLoc = '0;
    logic [RW-1:0] dec_bLoc = '0;
    logic [RW-1:0] dec_writeSelect = '0;
    logic          dec_load = 1'b0;
    logic          exe_ready = 1'b0;
    logic          flush = 1'b0;
    logic          operand_we, control_we, bubble;
`ifdef STALL_COUNT_EN
    logic [31:0]   stall_count;
`endif

    frame_issue_ctrl #(.FLUSH_CYCLES(FC), .STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_aLoc(dec_aLoc), .dec_bLoc(dec_bLoc), .dec_writeSelect(dec_writeSelect),
        .dec_load(dec_load), .exe_ready(exe_ready), .flush(flush),
        .operand_we(operand_we), .control_we(control_we), .bubble(bubble)
`ifdef STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bubbles still owed to a flush, whether the previous cycle was a
    // load-use bubble, and the most recent accepted load destination.
    int          m_flush_left = 0;
    bit          m_after_haz = 0;
    bit          m_ld_pending = 0;
    int          m_ld_reg = 0;
    bit [31:0]   m_sc = 0;

    typedef struct {
        bit rst, v, ld, exe, fl;
        int a, b, ws;
        bit [3:0] exp;   // {dec_ready, operand_we, control_we, bubble}
        int sc;          // expected stall count, -1 = not checked
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_haz();
        return dec_valid && m_ld_pending && m_ld_reg != 0 &&
               (int'(dec_aLoc) == m_ld_reg || int'(dec_bLoc) == m_ld_reg);
    endfunction

    function automatic bit [3:0] model_out();
        bit r, x;
        if (!reset) return 4'b0011;
        if (!exe_ready) return 4'b0000;
        r = (m_flush_left == 0) && !model_haz() && !flush;
        x = r && dec_valid;
        return {r, x, 1'b1, !x};
    endfunction

    task automatic model_step();
        bit haz, x, was_run;
        if (!reset) begin
            m_flush_left = 0; m_after_haz = 0; m_ld_pending = 0; m_ld_reg = 0; m_sc = 0;
            return;
        end
        haz = model_haz();
        x = exe_ready && dec_valid && m_flush_left == 0 && !haz && !flush;
        if (exe_ready && !x && (m_flush_left > 0 || m_after_haz || haz)) m_sc++;
        if (flush) begin
            m_flush_left = FC; m_ld_pending = 0; m_after_haz = 0;
        end else if (exe_ready) begin
            was_run = (m_flush_left == 0) && !m_after_haz;
            if (x) begin
                m_ld_pending = dec_load; m_ld_reg = int'(dec_writeSelect);
            end else begin
                m_ld_pending = 0;
            end
            if (m_flush_left > 0) m_flush_left--;
            m_after_haz = was_run && haz;
        end
    endtask

    task automatic drive(input bit rst, v, input int a, b, ws, input bit ld, exe, fl);
        reset = rst; dec_valid = v; dec_aLoc = RW'(a); dec_bLoc = RW'(b);
        dec_writeSelect = RW'(ws); dec_load = ld; exe_ready = exe; flush = fl;
    endtask

    task automatic tick(output logic rdy);
        @(negedge clk);
        rdy = dec_ready;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit rst, v, input int a, b, ws, input bit ld, exe, fl,
                       input bit [3:0] exp, input int sc);
        vec_t t;
        t.rst = rst; t.v = v; t.a = a; t.b = b; t.ws = ws; t.ld = ld;
        t.exe = exe; t.fl = fl; t.exp = exp; t.sc = sc;
        vq.push_back(t);
    endtask

    initial begin
        logic rdy;
        int   cnt;
        bit   done;

        //   rst v  a  b  ws ld exe fl  exp(r,ow,cw,b)  sc
        add(0, 1, 1, 2, 3, 0, 1, 0, 4'b0011, -1);   // reset state
        add(0, 1, 1, 2, 3, 0, 1, 0, 4'b0011, -1);
        add(1, 1, 1, 2, 5, 1, 1, 0, 4'b1110, 0);    // load x5
        add(1, 1, 5, 2, 6, 0, 1, 0, 4'b0011, -1);   // load-use bubble
        add(1, 1, 5, 2, 6, 0, 1, 0, 4'b1110, 1);    // stalled op issues
        add(1, 1, 6, 6, 7, 0, 1, 0, 4'b1110, -1);
        add(1, 1, 1, 1, 0, 1, 1, 0, 4'b1110, -1);   // load x0
        add(1, 1, 0, 0, 3, 0, 1, 0, 4'b1110, -1);   // x0 never hazards
        add(1, 1, 1, 2, 4, 0, 1, 1, 4'b0011, -1);   // flush pulse
        add(1, 1, 1, 2, 4, 0, 1, 0, 4'b0011, -1);
        add(1, 1, 1, 2, 4, 0, 1, 0, 4'b0011, -1);
        add(1, 1, 1, 2, 4, 0, 1, 0, 4'b1110, -1);   // ready on third cycle
        add(1, 1, 1, 2, 4, 0, 1, 1, 4'b0011, -1);   // flush then stall
        add(1, 1, 1, 2, 4, 0, 0, 0, 4'b0000, -1);
        add(1, 1, 1, 2, 4, 0, 0, 0, 4'b0000, -1);
        add(1, 1, 1, 2, 4, 0, 0, 0, 4'b0000, -1);
        add(1, 1, 1, 2, 4, 0, 1, 0, 4'b0011, -1);
        add(1, 1, 1, 2, 4, 0, 1, 0, 4'b0011, -1);
        add(1, 1, 1, 2, 4, 0, 1, 0, 4'b1110, -1);
        add(1, 0, 1, 2, 4, 0, 1, 0, 4'b1011, -1);   // idle decoder bubble
        add(1, 1, 1, 1, 3, 1, 1, 0, 4'b1110, -1);   // load x3
        add(1, 1, 3, 0, 2, 0, 1, 1, 4'b0011, -1);   // flush + hazard
        add(1, 1, 3, 0, 2, 0, 1, 0, 4'b0011, -1);
        add(1, 1, 3, 0, 2, 0, 1, 0, 4'b0011, -1);
        add(1, 1, 3, 0, 2, 0, 1, 0, 4'b1110, -1);   // last_load cleared
        add(1, 1, 1, 1, 2, 0, 1, 1, 4'b0011, -1);   // flush
        add(0, 1, 1, 1, 2, 0, 1, 0, 4'b0011, -1);   // reset mid-FLUSH
        add(1, 1, 1, 2, 3, 0, 1, 0, 4'b1110, 0);
        add(1, 1, 1, 2, 3, 0, 0, 0, 4'b0000, -1);   // stalled frame
        add(1, 1, 1, 2, 3, 0, 1, 0, 4'b1110, -1);
        add(1, 1, 1, 2, 4, 1, 1, 0, 4'b1110, -1);   // load x4
        add(1, 1, 4, 2, 5, 0, 0, 0, 4'b0000, -1);   // hazard held by stall
        add(1, 1, 4, 2, 5, 0, 1, 0, 4'b0011, -1);
        add(1, 1, 4, 2, 5, 0, 1, 0, 4'b1110, -1);
        add(1, 1, 1, 2, 2, 1, 1, 0, 4'b1110, -1);   // load x2
        add(1, 1, 2, 1, 5, 0, 1, 0, 4'b0011, -1);   // hazard bubble
        add(0, 1, 2, 1, 5, 0, 1, 0, 4'b0011, -1);   // reset mid-LDUSE
        add(1, 1, 2, 1, 5, 0, 1, 0, 4'b1110, -1);

        @(posedge clk); #1;
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].v, vq[i].a, vq[i].b, vq[i].ws, vq[i].ld, vq[i].exe, vq[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d", i), {dec_ready, operand_we, control_we, bubble}, vq[i].exp);
`ifdef STALL_COUNT_EN
            if (vq[i].sc >= 0) chk($sformatf("vec%0d_sc", i), stall_count, vq[i].sc);
`endif
            model_step();
            @(posedge clk); #1;
        end

        // Flush again while flushing: the bubble run restarts at FC.
        drive(1, 1, 1, 2, 3, 0, 1, 1); tick(rdy);
        drive(1, 1, 1, 2, 3, 0, 1, 0); tick(rdy);
        drive(1, 1, 1, 2, 3, 0, 1, 1); tick(rdy);
        drive(1, 1, 1, 2, 3, 0, 1, 0);
        cnt = 0; done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick(rdy);
            if (rdy) done = 1; else cnt++;
        end
        chk("reflush_done", done, 1);
        chk("reflush_bubbles", cnt, FC);

        // Random stimulus against the model.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 19) == 0);
            @(negedge clk);
            chk("rand_out", {dec_ready, operand_we, control_we, bubble}, model_out());
`ifdef STALL_COUNT_EN
            chk("rand_sc", stall_count, m_sc);
`endif
            model_step();
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
